// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution loop sequencer: state encoding and
// sizing helper for the post-MAC drain counter.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Drain counter loads latency-1 and counts down to zero, so it only needs
    // to hold values up to latency-1.
    function automatic int lat_cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// Wrapping up-counter stage for one loop index; wrap flags the step from the
// bound back to zero so the next (outer) stage can be enabled from it.
module conv_idx_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == last);
    assign wrap    = en && at_last;
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_loop_sequencer.sv
// Sequences channel / kernel-row / kernel-column MAC issue for one output
// pixel, then waits out the MAC pipeline before pulsing Done.
module conv_loop_sequencer
    import conv_seq_pkg::*;
#(
    parameter int CH_BITWIDTH = 2,
    parameter int K_BITWIDTH  = 2,
    parameter int MAC_LATENCY = 2
) (
    input  logic                   CLS_Clk,
    input  logic                   CLS_Clr,
    input  logic                   CLS_Start,
    input  logic                   CLS_Abort,
    input  logic                   CLS_Stall,
    input  logic [CH_BITWIDTH-1:0] CLS_ChLast,
    input  logic [K_BITWIDTH-1:0]  CLS_KLast,
    output logic [CH_BITWIDTH-1:0] CLS_ChIdx,
    output logic [K_BITWIDTH-1:0]  CLS_KRow,
    output logic [K_BITWIDTH-1:0]  CLS_KCol,
    output logic                   CLS_AccClr,
    output logic                   CLS_MacEn,
    output logic                   CLS_Last,
    output logic                   CLS_Busy,
    output logic                   CLS_Done
);

    localparam int LAT_W = lat_cnt_width(MAC_LATENCY);
    localparam logic [LAT_W-1:0] DRAIN_LOAD = LAT_W'(MAC_LATENCY - 1);

    state_e                 state_q, state_d;
    logic [CH_BITWIDTH-1:0] ch_last_q, ch_last_d;
    logic [K_BITWIDTH-1:0]  k_last_q, k_last_d;
    logic [LAT_W-1:0]       drain_q, drain_d;

    logic [CH_BITWIDTH-1:0] ch_idx_q, ch_idx_d;
    logic [K_BITWIDTH-1:0]  k_row_q, k_row_d;
    logic [K_BITWIDTH-1:0]  k_col_q, k_col_d;
    logic                   acc_clr_q, acc_clr_d;
    logic                   mac_en_q, mac_en_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   issue;
    logic                   cnt_clr_n;
    logic [CH_BITWIDTH-1:0] ch_cnt;
    logic [K_BITWIDTH-1:0]  row_cnt;
    logic [K_BITWIDTH-1:0]  col_cnt;
    logic                   col_wrap, row_wrap, ch_wrap;

    always_comb begin
        state_d   = state_q;
        ch_last_d = ch_last_q;
        k_last_d  = k_last_q;
        drain_d   = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (CLS_Start) begin
                    state_d   = ST_CLEAR;
                    ch_last_d = CLS_ChLast;
                    k_last_d  = CLS_KLast;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                // last_q marks that the final MAC is on the bus this cycle.
                if (last_q) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (CLS_Abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Counters hold the index of the next MAC to issue; the output registers
    // capture it on issue so a stall keeps showing the last issued triple.
    assign issue     = (state_d == ST_RUN) && !CLS_Stall;
    assign cnt_clr_n = CLS_Clr && (state_d == ST_RUN);

    conv_idx_counter #(.W(K_BITWIDTH)) u_col_cnt (
        .clk   (CLS_Clk),
        .clr_n (cnt_clr_n),
        .en    (issue),
        .last  (k_last_q),
        .count (col_cnt),
        .wrap  (col_wrap)
    );

    conv_idx_counter #(.W(K_BITWIDTH)) u_row_cnt (
        .clk   (CLS_Clk),
        .clr_n (cnt_clr_n),
        .en    (col_wrap),
        .last  (k_last_q),
        .count (row_cnt),
        .wrap  (row_wrap)
    );

    conv_idx_counter #(.W(CH_BITWIDTH)) u_ch_cnt (
        .clk   (CLS_Clk),
        .clr_n (cnt_clr_n),
        .en    (row_wrap),
        .last  (ch_last_q),
        .count (ch_cnt),
        .wrap  (ch_wrap)
    );

    always_comb begin
        acc_clr_d = (state_d == ST_CLEAR);
        mac_en_d  = issue;
        last_d    = ch_wrap;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        ch_idx_d  = '0;
        k_row_d   = '0;
        k_col_d   = '0;
        if (issue) begin
            ch_idx_d = ch_cnt;
            k_row_d  = row_cnt;
            k_col_d  = col_cnt;
        end else if (state_d == ST_RUN) begin
            ch_idx_d = ch_idx_q;
            k_row_d  = k_row_q;
            k_col_d  = k_col_q;
        end
    end

    always_ff @(posedge CLS_Clk) begin
        if (!CLS_Clr) begin
            state_q   <= ST_IDLE;
            ch_last_q <= '0;
            k_last_q  <= '0;
            drain_q   <= '0;
            ch_idx_q  <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
            acc_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_last_q <= ch_last_d;
            k_last_q  <= k_last_d;
            drain_q   <= drain_d;
            ch_idx_q  <= ch_idx_d;
            k_row_q   <= k_row_d;
            k_col_q   <= k_col_d;
            acc_clr_q <= acc_clr_d;
            mac_en_q  <= mac_en_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CLS_ChIdx  = ch_idx_q;
    assign CLS_KRow   = k_row_q;
    assign CLS_KCol   = k_col_q;
    assign CLS_AccClr = acc_clr_q;
    assign CLS_MacEn  = mac_en_q;
    assign CLS_Last   = last_q;
    assign CLS_Busy   = busy_q;
    assign CLS_Done   = done_q;

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Bench for conv_loop_sequencer: queue-based reference of the MAC issue
// order compared every cycle, plus directed scenarios with literal timings.
`timescale 1ns/1ps
module tb_conv_loop_sequencer;

    localparam int CHW = 2;
    localparam int KW  = 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           clr_n, start, abort, stall;
    logic [CHW-1:0] ch_last;
    logic [KW-1:0]  k_last;
    logic [CHW-1:0] ch_idx;
    logic [KW-1:0]  k_row, k_col;
    logic           acc_clr, mac_en, last, busy, done;

    conv_loop_sequencer #(
        .CH_BITWIDTH (CHW),
        .K_BITWIDTH  (KW),
        .MAC_LATENCY (LAT)
    ) dut (
        .CLS_Clk    (clk),
        .CLS_Clr    (clr_n),
        .CLS_Start  (start),
        .CLS_Abort  (abort),
        .CLS_Stall  (stall),
        .CLS_ChLast (ch_last),
        .CLS_KLast  (k_last),
        .CLS_ChIdx  (ch_idx),
        .CLS_KRow   (k_row),
        .CLS_KCol   (k_col),
        .CLS_AccClr (acc_clr),
        .CLS_MacEn  (mac_en),
        .CLS_Last   (last),
        .CLS_Busy   (busy),
        .CLS_Done   (done)
    );

    int total  = 0;
    int passed = 0;

    // Reference: a job is a queue of (ch,row,col) triples, column fastest.
    bit m_active, m_clear, m_done_shown;
    int m_drain;
    int m_q[$];
    int m_ch, m_row, m_col;

    logic [CHW-1:0] e_ch;
    logic [KW-1:0]  e_row, e_col;
    logic           e_acc, e_mac, e_last, e_busy, e_done;

    int  edge_n = 0;
    int  base   = 0;
    bit  cmp_en = 1'b0;
    int  done_cnt, mac_cnt, done_rel, last_rel, first_mac_rel;

    task automatic model_step();
        edge_n++;
        e_acc = 1'b0; e_mac = 1'b0; e_last = 1'b0; e_done = 1'b0;
        if (!clr_n || (m_active && abort)) begin
            m_active = 1'b0; m_clear = 1'b0; m_done_shown = 1'b0;
            m_q.delete(); m_drain = 0;
            m_ch = 0; m_row = 0; m_col = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_clear = 1'b1; m_done_shown = 1'b0;
                m_q.delete(); m_drain = 0;
                m_ch = 0; m_row = 0; m_col = 0;
                for (int c = 0; c <= int'(ch_last); c++)
                    for (int r = 0; r <= int'(k_last); r++)
                        for (int k = 0; k <= int'(k_last); k++)
                            m_q.push_back((c << 16) | (r << 8) | k);
                e_acc = 1'b1;
            end
        end else if (m_clear || m_q.size() > 0) begin
            m_clear = 1'b0;
            if (!stall) begin
                int v;
                v = m_q.pop_front();
                m_ch = v >> 16; m_row = (v >> 8) & 255; m_col = v & 255;
                e_mac = 1'b1;
                if (m_q.size() == 0) begin
                    e_last  = 1'b1;
                    m_drain = LAT;
                end
            end
        end else begin
            m_ch = 0; m_row = 0; m_col = 0;
            if (m_drain > 0) m_drain--;
            else if (!m_done_shown) begin e_done = 1'b1; m_done_shown = 1'b1; end
            else m_active = 1'b0;
        end
        e_busy = m_active;
        e_ch   = CHW'(m_ch);
        e_row  = KW'(m_row);
        e_col  = KW'(m_col);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    endtask

    // Per-cycle compare of every output against the reference.
    initial begin
        logic [10:0] act_v, exp_v;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                act_v = {ch_idx, k_row, k_col, acc_clr, mac_en, last, busy, done};
                exp_v = {e_ch, e_row, e_col, e_acc, e_mac, e_last, e_busy, e_done};
                total++;
                if (act_v === exp_v) passed++;
                else $display("FAIL cycle_compare edge=%0d actual={ch,row,col,clr,mac,last,busy,done}=%b required=%b",
                              edge_n, act_v, exp_v);
                if (mac_en === 1'b1) begin
                    mac_cnt++;
                    if (first_mac_rel < 0) first_mac_rel = edge_n - base;
                end
                if (last === 1'b1) last_rel = edge_n - base;
                if (done === 1'b1) begin
                    done_cnt++;
                    done_rel = edge_n - base;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic drive(input bit c, input bit s, input bit a, input bit st,
                         input int chl, input int kl);
        clr_n = c; start = s; abort = a; stall = st;
        ch_last = CHW'(chl); k_last = KW'(kl);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic begin_run();
        base = edge_n; mac_cnt = 0; done_cnt = 0;
        done_rel = -1; last_rel = -1; first_mac_rel = -1;
    endtask

    task automatic full_run(input string name);
        begin_run();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 2);
        run_idle(45);
        check({name, "_done_cycle"}, done_rel, 40);
        check({name, "_mac_count"}, mac_cnt, 36);
        check({name, "_done_count"}, done_cnt, 1);
        $display("run %s: done@%0d macs=%0d", name, done_rel, mac_cnt);
    endtask

    initial begin
        m_active = 0; m_clear = 0; m_done_shown = 0; m_drain = 0;
        m_ch = 0; m_row = 0; m_col = 0;
        cmp_en = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset_busy", int'(busy), 0);
        check("reset_macen", int'(mac_en), 0);
        run_idle(2);

        // Minimum size: one MAC.
        begin_run();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        run_idle(8);
        check("min_done_cycle", done_rel, 5);
        check("min_mac_count", mac_cnt, 1);
        check("min_first_mac", first_mac_rel, 2);
        check("min_last_cycle", last_rel, 2);
        check("min_done_count", done_cnt, 1);
        $display("run min: done@%0d macs=%0d", done_rel, mac_cnt);

        // Full size 4 channels x 3x3.
        begin_run();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 2);
        run_idle(45);
        check("full_done_cycle", done_rel, 40);
        check("full_mac_count", mac_cnt, 36);
        check("full_first_mac", first_mac_rel, 2);
        check("full_last_cycle", last_rel, 37);
        $display("run full: done@%0d macs=%0d", done_rel, mac_cnt);

        // Stall sampled at edges 3..5 costs three MAC slots.
        begin_run();
        for (int r = 0; r < 16; r++)
            drive(1'b1, r == 0, 1'b0, (r >= 3) && (r <= 5), 0, 1);
        check("stall_done_cycle", done_rel, 11);
        check("stall_mac_count", mac_cnt, 4);
        check("stall_last_cycle", last_rel, 8);
        $display("run stall: done@%0d macs=%0d", done_rel, mac_cnt);

        // Abort at edge 10: MACs in cycles 2..10 only, no Done.
        begin_run();
        for (int r = 0; r <= 10; r++)
            drive(1'b1, r == 0, r == 10, 1'b0, 3, 2);
        check("abort_busy", int'(busy), 0);
        check("abort_mac_count", mac_cnt, 9);
        run_idle(4);
        check("abort_done_count", done_cnt, 0);
        $display("run abort: macs=%0d dones=%0d", mac_cnt, done_cnt);
        full_run("after_abort");

        // Reset mid-run, Start ignored while reset held.
        begin_run();
        for (int r = 0; r <= 8; r++)
            drive(r != 8, r == 0, 1'b0, 1'b0, 3, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3, 2);
        check("reset_mid_busy", int'(busy), 0);
        run_idle(3);
        check("reset_mid_busy_after", int'(busy), 0);
        check("reset_mid_done_count", done_cnt, 0);
        $display("run reset_mid: macs=%0d dones=%0d", mac_cnt, done_cnt);
        full_run("after_reset");

        // Start during RUN and during DONE, bounds wiggling mid-run.
        begin_run();
        for (int r = 0; r < 46; r++)
            drive(1'b1, (r == 0) || (r == 10) || (r == 40), 1'b0, 1'b0,
                  (r == 0) ? 3 : (r % 4), (r == 0) ? 2 : (r % 3));
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_mac_count", mac_cnt, 36);
        check("busy_start_done_cycle", done_rel, 40);
        check("busy_start_idle", int'(busy), 0);
        $display("run busy_start: done@%0d macs=%0d", done_rel, mac_cnt);

        // Randomized traffic against the reference.
        begin_run();
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        $display("run random: macs=%0d dones=%0d", mac_cnt, done_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
